masker_merge_pipe: RTL
======================

// Module: masker_merge_pipe
// PURPOSE
// - Downstream stage of the 4-bit rotator slices: consumes the 32-bit rotated word
//   and merges it with A-bus data under a left/right bit mask.
// - Produces the ALU/OB operand for byte-field extract and deposit microinstructions.
// - Input handshake is valid/ready; a 2-entry output queue decouples the consumer.
// - in_ready never depends combinationally on out_ready.
// PARAMETERS
// - WIDTH   32  data width; must be a power of two, >= 8
// - PW      5   mask position width = log2(WIDTH)
// PORTS
// - clk        in   1      system clock; all state changes on rising edge
// - reset      in   1      synchronous, active-high reset
// - in_valid   in   1      r_in/a_in/mode/left_pos/right_pos are valid this cycle
// - in_ready   out  1      stage can accept; transfer when in_valid & in_ready
// - r_in       in   WIDTH  rotated data from the shifter slices
// - a_in       in   WIDTH  A-bus data, merged outside the mask
// - left_pos   in   PW     highest mask bit (inclusive)
// - right_pos  in   PW     lowest mask bit (inclusive)
// - mode       in   2      00 pass r, 01 merge, 10 extract, 11 pass a
// - out_valid  out  1      ob/wrap hold the queue head
// - out_ready  in   1      consumer takes head when out_valid & out_ready
// - ob         out  WIDTH  merged result (queue head)
// - wrap       out  1      head entry used a wrapped mask (left_pos < right_pos)
// - ob_par     out  1      odd parity of ob; port exists only with MASKER_PARITY_EN
// BEHAVIOUR
// - Reset: queue emptied, count=0. Outputs after reset:
//   - out_valid=0, ob=0, wrap=0, ob_par=1
//   - in_ready=1 in the first cycle after reset deasserts
// - Mask m[i]:
//   - right_pos <= left_pos: m[i]=1 for right_pos <= i <= left_pos
//   - left_pos < right_pos (wrap=1): m[i]=1 for i >= right_pos or i <= left_pos
//   - left_pos == right_pos: exactly one mask bit set
// - Result by mode:
//   - 00: r_in
//   - 01: (r_in & m) | (a_in & ~m)
//   - 10: r_in & m
//   - 11: a_in
//   - Mask and result are computed at accept time and stored in the queue entry.
// - Latency: accepted on edge N -> out_valid=1 with that entry's ob from edge N
//   (one cycle). Data is never combinational from in_* to ob.
// - Queue: 2 entries, head/tail pointers, count 0..2. in_ready = (count != 2).
//   - Push only: count+1. Pop only: count-1.
//   - Push and pop in the same cycle: count unchanged; the head advances and the
//     new entry is written at the tail. Legal at count=1, including a one-deep
//     stream at full rate.
//   - count=0 with push: entry appears the next cycle. No bypass.
// - Pointers are 1 bit and wrap 1->0. Overflow cannot occur because of in_ready.
//   A pop with out_valid=0 is ignored.
// - While out_valid=1 and out_ready=0, ob/wrap/ob_par stay stable.
// - Reset mid-operation: both queued entries are discarded; no partial output.
// CONFIGURATION
// - MASKER_PARITY_EN defined:
//   - each queue entry stores a parity bit computed at accept time as ~^result
//   - ob_par = that bit of the head entry; reads 1 when the queue is empty
// - MASKER_PARITY_EN undefined:
//   - ob_par port and parity storage are absent
//   - all other behaviour is identical
// TESTING
// - Reset then idle -> out_valid=0, in_ready=1, ob=0 for 3 cycles.
// - mode=01, r=FFFFFFFF, a=00000000, left=15, right=8 ->
//   next cycle ob=0000FF00, wrap=0.
// - mode=01, r=00000000, a=FFFFFFFF, left=3, right=28 ->
//   ob=0FFFFFF0, wrap=1. Also mode=10, left=right=31, r=80000001 -> ob=80000000.
// - Hold out_ready=0 and push 3 words (11111111, 22222222, 33333333) ->
//   in_ready=0 after the second accept. Third word held off. Then out_ready=1 ->
//   ob sequence 11111111, 22222222, 33333333 with no loss or duplication.
// - in_valid=1 and out_ready=1 continuously, 8 words ->
//   one output per cycle, in order, count stays 1.
// - Two entries queued, then reset for 1 cycle -> out_valid=0 next cycle.
//   With MASKER_PARITY_EN: ob=00000007 gives ob_par=0.

Source files
------------

// File: rtl/masker_merge_pipe.sv
// masker_merge_pipe - left/right bit-mask merge of rotated and A-bus data into a 2-entry output queue.
// Optional odd-parity output on the head entry when MASKER_PARITY_EN is defined.
module masker_merge_pipe #(
  parameter int WIDTH = 32,
  parameter int PW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [PW-1:0]    left_pos,
  input  logic [PW-1:0]    right_pos,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ob,
`ifdef MASKER_PARITY_EN
  output logic             ob_par,
`endif
  output logic             wrap
);

  localparam logic [PW-1:0]    MAX_POS = PW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONES    = '1;

  logic [WIDTH-1:0] data_q [2];
  logic             wrap_q [2];
`ifdef MASKER_PARITY_EN
  logic             par_q  [2];
`endif
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic [WIDTH-1:0] hi_mask, lo_mask, mask, result;
  logic             wrap_in, push, pop;

  // hi_mask covers bits 0..left_pos, lo_mask covers right_pos..MSB
  always_comb begin
    hi_mask = ONES >> (MAX_POS - left_pos);
    lo_mask = ONES << right_pos;
    wrap_in = (left_pos < right_pos);
    mask    = wrap_in ? (hi_mask | lo_mask) : (hi_mask & lo_mask);
    case (mode)
      2'b00:   result = r_in;
      2'b01:   result = (r_in & mask) | (a_in & ~mask);
      2'b10:   result = r_in & mask;
      default: result = a_in;
    endcase
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      wrap_q[0] <= 1'b0;
      wrap_q[1] <= 1'b0;
`ifdef MASKER_PARITY_EN
      par_q[0]  <= 1'b1;
      par_q[1]  <= 1'b1;
`endif
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        data_q[tail_q] <= result;
        wrap_q[tail_q] <= wrap_in;
`ifdef MASKER_PARITY_EN
        par_q[tail_q]  <= ~^result;
`endif
      end
    end
  end

  // Empty queue presents zeros so stale entries never leak onto the bus
  assign ob   = out_valid ? data_q[head_q] : '0;
  assign wrap = out_valid ? wrap_q[head_q] : 1'b0;
`ifdef MASKER_PARITY_EN
  assign ob_par = out_valid ? par_q[head_q] : 1'b1;
`endif

endmodule
